// File: rtl/mult_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mult_sequencer_pkg
//   Shared definitions for the multiply sequencer and the 8-register / ALU
//   datapath it controls: register indices, ALU opcodes, FSM state encoding,
//   the per-state control word, and a helper that maps a state to the select
//   and opcode values the datapath must see while in that state.
//
//   Optional feature macro used by mult_sequencer: MULT_SEQ_OVF_ABORT_EN.
// -----------------------------------------------------------------------------
package mult_sequencer_pkg;

    // Register-select and opcode widths are fixed by the 8-register file and
    // the 3-bit ALU opcode space.
    localparam int SELECTIONDECO  = 3;
    localparam int SELECTIONALU   = 3;
    localparam int DEF_DATAWIDTH  = 8;

    typedef logic [SELECTIONDECO-1:0] reg_sel_t;
    typedef logic [SELECTIONALU-1:0]  alu_op_t;

    // Register map
    localparam reg_sel_t REG_ACC  = 3'd0;  // accumulator / result
    localparam reg_sel_t REG_A    = 3'd1;  // multiplicand (read only)
    localparam reg_sel_t REG_CNT  = 3'd2;  // multiplier, counted down to 0
    localparam reg_sel_t REG_ONE  = 3'd6;  // fixed constant 1
    localparam reg_sel_t REG_NOWR = 3'd7;  // write parking slot (no effect)

    // ALU opcodes
    localparam alu_op_t ALU_ADD   = 3'd0;  // A + B
    localparam alu_op_t ALU_SUB   = 3'd1;  // A - B
    localparam alu_op_t ALU_PASSA = 3'd2;  // A

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_CHK  = 3'd2,
        ST_ADD  = 3'd3,
        ST_DEC  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Everything the sequencer drives towards the datapath and the host.
    typedef struct packed {
        reg_sel_t sel_a;
        reg_sel_t sel_b;
        reg_sel_t sel_c;
        alu_op_t  alu;
        logic     busy;
        logic     done;
    } ctrl_t;

    // Control word for a given state. Outputs are Moore: the word is computed
    // from the next state and registered, so it lines up with state_q.
    function automatic ctrl_t state_drive(input state_e st);
        ctrl_t c;
        c.sel_a = 3'd0;
        c.sel_b = 3'd0;
        c.sel_c = REG_NOWR;
        c.alu   = ALU_PASSA;
        c.busy  = 1'b1;
        c.done  = 1'b0;
        case (st)
            ST_IDLE: begin
                c.busy = 1'b0;
            end
            ST_CLR: begin
                // A - A = 0 written into the accumulator
                c.sel_a = REG_A;
                c.sel_b = REG_A;
                c.alu   = ALU_SUB;
                c.sel_c = REG_ACC;
            end
            ST_CHK: begin
                // pass the counter through so the ALU zero flag tests it
                c.sel_a = REG_CNT;
                c.alu   = ALU_PASSA;
            end
            ST_ADD: begin
                c.sel_a = REG_ACC;
                c.sel_b = REG_A;
                c.alu   = ALU_ADD;
                c.sel_c = REG_ACC;
            end
            ST_DEC: begin
                c.sel_a = REG_CNT;
                c.sel_b = REG_ONE;
                c.alu   = ALU_SUB;
                c.sel_c = REG_CNT;
            end
            ST_DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c.busy = 1'b0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mult_sequencer_iter_counter.sv
// -----------------------------------------------------------------------------
// mult_sequencer_iter_counter
//   Free-standing iteration counter used as a runaway guard for the multiply
//   loop. Counts enabled cycles; tc flags the all-ones terminal value.
//
//   Ports
//     clk  in   system clock
//     rst  in   synchronous active-high reset (counter to 0)
//     clr  in   synchronous clear (counter to 0)
//     en   in   increment enable
//     tc   out  high while the count equals 2^WIDTH-1
// -----------------------------------------------------------------------------
module mult_sequencer_iter_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = &count_q;

endmodule

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
//   Controller for the 8-register / ALU datapath. Computes
//   R_ACC = R_A * R_CNT by repeated addition, with a start/done handshake so
//   a host FSM can share the datapath. R_CNT is destroyed (counted to 0).
//
//   Ports
//     clk        in   system clock
//     rst        in   synchronous reset, active-high
//     sStart     in   start request, only looked at in IDLE
//     sZero      in   ALU zero flag (combinational from current selects)
//     sCarry     in   ALU carry flag
//     sBusy      out  high in every state except IDLE
//     sDone      out  one-cycle pulse, result valid in REG_ACC
//     sErr       out  sticky error, cleared when a start is accepted
//     sSelDecoA  out  bus-A mux select
//     sSelDecoB  out  bus-B mux select
//     sSelDecoC  out  write-decoder select (REG_NOWR = no write)
//     sSelAlu    out  ALU opcode
//
//   Build option
//     MULT_SEQ_OVF_ABORT_EN : carry out of an ADD step flags sErr and aborts
//                             straight to DONE (accumulator keeps the wrapped
//                             sum). Without it the product wraps silently.
// -----------------------------------------------------------------------------
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sStart,
    input  logic                     sZero,
    input  logic                     sCarry,
    output logic                     sBusy,
    output logic                     sDone,
    output logic                     sErr,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;
    logic   err_q,   err_d;

    logic   iter_clr;
    logic   iter_en;
    logic   iter_tc;

    // Counts ADD steps of the current operation; reaching all-ones without
    // the multiplier hitting zero means the datapath is misbehaving.
    mult_sequencer_iter_counter #(
        .WIDTH (DATAWIDTH)
    ) u_iter_counter (
        .clk (clk),
        .rst (rst),
        .clr (iter_clr),
        .en  (iter_en),
        .tc  (iter_tc)
    );

`ifndef MULT_SEQ_OVF_ABORT_EN
    // Carry is irrelevant when the product is allowed to wrap.
    logic unused_carry;
    assign unused_carry = sCarry;
`endif

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        iter_clr = 1'b0;
        iter_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sStart) begin
                    state_d  = ST_CLR;
                    err_d    = 1'b0;
                    iter_clr = 1'b1;
                end
            end
            ST_CLR: begin
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (sZero) begin
                    state_d = ST_DONE;
                end else if (iter_tc) begin
                    // runaway guard: multiplier never reached zero
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                iter_en = 1'b1;
`ifdef MULT_SEQ_OVF_ABORT_EN
                if (sCarry) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DEC;
                end
`else
                state_d = ST_DEC;
`endif
            end
            ST_DEC: begin
                state_d = ST_CHK;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ctrl_d = state_drive(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            ctrl_q  <= state_drive(ST_IDLE);
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign sBusy     = ctrl_q.busy;
    assign sDone     = ctrl_q.done;
    assign sErr      = err_q;
    assign sSelDecoA = ctrl_q.sel_a;
    assign sSelDecoB = ctrl_q.sel_b;
    assign sSelDecoC = ctrl_q.sel_c;
    assign sSelAlu   = ctrl_q.alu;

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
//   Self-checking bench for mult_sequencer. The bench owns a small register
//   file + ALU stub driven by the sequencer's selects, and compares results,
//   latencies and flags against expectations derived from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

`ifdef MULT_SEQ_OVF_ABORT_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sStart = 1'b0;
    logic       sZero;
    logic       sCarry;
    logic       sBusy;
    logic       sDone;
    logic       sErr;
    logic [2:0] sSelDecoA;
    logic [2:0] sSelDecoB;
    logic [2:0] sSelDecoC;
    logic [2:0] sSelAlu;

    always #5 clk = ~clk;

    mult_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .sStart    (sStart),
        .sZero     (sZero),
        .sCarry    (sCarry),
        .sBusy     (sBusy),
        .sDone     (sDone),
        .sErr      (sErr),
        .sSelDecoA (sSelDecoA),
        .sSelDecoB (sSelDecoB),
        .sSelDecoC (sSelDecoC),
        .sSelAlu   (sSelAlu)
    );

    // ---------------- datapath stub: register file + ALU ----------------
    logic [7:0] rf [8];
    logic       load_en = 1'b0;
    logic [7:0] load_a = 8'd0;
    logic [7:0] load_cnt = 8'd0;
    logic       stuck_zero = 1'b0;
    logic [7:0] op_a, op_b, alu_y;
    logic       alu_c;

    always_comb begin
        op_a = (sSelDecoA == 3'd6) ? 8'd1 : (sSelDecoA == 3'd7) ? 8'd0 : rf[sSelDecoA];
        op_b = (sSelDecoB == 3'd6) ? 8'd1 : (sSelDecoB == 3'd7) ? 8'd0 : rf[sSelDecoB];
    end

    always_comb begin
        alu_y = op_a;
        alu_c = 1'b0;
        case (sSelAlu)
            3'd0:    {alu_c, alu_y} = {1'b0, op_a} + {1'b0, op_b};
            3'd1:    {alu_c, alu_y} = {1'b0, op_a} - {1'b0, op_b};
            default: begin end
        endcase
    end

    assign sZero  = stuck_zero ? 1'b0 : (alu_y == 8'd0);
    assign sCarry = alu_c;

    always @(posedge clk) begin
        if (load_en) begin
            rf[0] <= 8'hA5;  // junk, must be cleared by the sequencer
            rf[1] <= load_a;
            rf[2] <= load_cnt;
        end else if (sSelDecoC < 3'd6) begin
            rf[sSelDecoC] <= alu_y;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: product by plain arithmetic; done cycle = 3N+3, or for an
    // overflow abort, the cycle right after the offending (k-th) ADD step,
    // which sits in cycle 3k.
    task automatic model(input int a, input int n, output int acc, output int cyc,
                         output bit err);
        int s;
        s   = 0;
        acc = (a * n) % 256;
        cyc = 3 * n + 3;
        err = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (OVF && (s + a > 255)) begin
                acc = (s + a) % 256;
                cyc = 3 * k + 1;
                err = 1'b1;
                return;
            end
            s = s + a;
        end
    endtask

    task automatic load(input int a, input int n);
        @(negedge clk);
        load_en  = 1'b1;
        load_a   = a[7:0];
        load_cnt = n[7:0];
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Load operands, pulse sStart, follow the operation to sDone (bounded),
    // then verify the one-cycle done pulse and busy release.
    task automatic run_op(input int a, input int n, output int done_cyc,
                          output bit err, output bit saw_add, output bit busy_ok);
        load(a, n);
        @(negedge clk);
        sStart   = 1'b1;
        done_cyc = -1;
        err      = 1'b0;
        saw_add  = 1'b0;
        busy_ok  = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 1) sStart = 1'b0;
            if (!sBusy) busy_ok = 1'b0;
            if (sSelAlu == 3'd0 && sSelDecoC == 3'd0) saw_add = 1'b1;
            if (sDone) begin
                done_cyc = c;
                err      = sErr;
                break;
            end
        end
        @(negedge clk);
        check("post_done_busy", int'(sBusy), 0);
        check("post_done_pulse", int'(sDone), 0);
    endtask

    typedef struct {
        int a;
        int n;
        int acc;
        int cyc;
        bit err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int  dc, acc_e, cyc_e, dones, busy_cnt, d1, d2, acc1, busy7;
        bit  err, saw_add, busy_ok, err_e;

        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dc, acc_e, cyc_e, dones, busy_cnt, d1, d2, acc1, busy7;
        bit  err, saw_add, busy_ok, err_e;

        tbl[0] = '{a: 3,   n: 2,  acc: 6,   cyc: 9,               err: 1'b0};
        tbl[1] = '{a: 7,   n: 0,  acc: 0,   cyc: 3,               err: 1'b0};
        tbl[2] = '{a: 255, n: 2,  acc: 254, cyc: OVF ? 7 : 9,     err: OVF};
        tbl[3] = '{a: 5,   n: 3,  acc: 15,  cyc: 12,              err: 1'b0};
        tbl[4] = '{a: 16,  n: 16, acc: 0,   cyc: OVF ? 49 : 51,   err: OVF};
        tbl[5] = '{a: 0,   n: 5,  acc: 0,   cyc: 18,              err: 1'b0};
        tbl[6] = '{a: 1,   n: 1,  acc: 1,   cyc: 6,               err: 1'b0};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_selA",  int'(sSelDecoA), 0);
        check("rst_selB",  int'(sSelDecoB), 0);
        check("rst_selC",  int'(sSelDecoC), 7);
        check("rst_alu",   int'(sSelAlu),   2);
        check("rst_busy",  int'(sBusy),     0);
        check("rst_done",  int'(sDone),     0);
        check("rst_err",   int'(sErr),      0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(sBusy), 0);

        // ---- directed table ----
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].n, dc, err, saw_add, busy_ok);
            $display("vec %0d: A=%0d CNT=%0d -> done@%0d acc=%0d err=%0d",
                     i, tbl[i].a, tbl[i].n, dc, rf[0], err);
            check("tbl_cycle", dc, tbl[i].cyc);
            check("tbl_acc", int'(rf[0]), tbl[i].acc);
            check("tbl_err", int'(err), int'(tbl[i].err));
            check("tbl_saw_add", int'(saw_add), int'(tbl[i].n != 0));
            check("tbl_busy", int'(busy_ok), 1);
            if (!tbl[i].err) check("tbl_cnt", int'(rf[2]), 0);
        end

        // ---- reset mid-operation (A=5, CNT=3, rst during cycle 4) ----
        load(5, 3);
        @(negedge clk);
        sStart = 1'b1;
        @(negedge clk);                  // cycle 1
        sStart = 1'b0;
        repeat (3) @(negedge clk);       // cycles 2..4
        rst = 1'b1;
        @(negedge clk);                  // cycle 5
        check("midrst_busy", int'(sBusy), 0);
        check("midrst_selC", int'(sSelDecoC), 7);
        check("midrst_alu",  int'(sSelAlu), 2);
        check("midrst_selA", int'(sSelDecoA), 0);
        rst   = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (sDone) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_op(5, 3, dc, err, saw_add, busy_ok);
        $display("midrst rerun: done@%0d acc=%0d", dc, rf[0]);
        check("midrst_rerun_acc", int'(rf[0]), 15);
        check("midrst_rerun_cyc", dc, 12);

        // ---- sStart pulsed while busy is ignored ----
        load(4, 3);
        @(negedge clk);
        sStart = 1'b1;
        dc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) sStart = 1'b0;
            if (c == 3) sStart = 1'b1;
            if (c == 4) sStart = 1'b0;
            if (sDone) begin
                dc = c;
                break;
            end
        end
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (sBusy) busy_cnt++;
        end
        $display("busy pulse: done@%0d acc=%0d busy_after=%0d", dc, rf[0], busy_cnt);
        check("pulse_cycle", dc, 12);
        check("pulse_acc", int'(rf[0]), 12);
        check("pulse_no_restart", busy_cnt, 0);

        // ---- sStart held high: back-to-back ops (A=2,CNT=1 then CNT=0) ----
        load(2, 1);
        @(negedge clk);
        sStart = 1'b1;
        d1 = -1; d2 = -1; acc1 = -1; busy7 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 7) busy7 = int'(sBusy);
            if (sDone) begin
                if (d1 < 0) begin
                    d1   = c;
                    acc1 = int'(rf[0]);
                end else begin
                    d2     = c;
                    sStart = 1'b0;
                    break;
                end
            end
        end
        sStart = 1'b0;
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (sBusy) busy_cnt++;
        end
        $display("held start: done@%0d,%0d acc1=%0d acc2=%0d", d1, d2, acc1, rf[0]);
        check("held_done1", d1, 6);
        check("held_acc1", acc1, 2);
        check("held_idle_gap", busy7, 0);
        check("held_done2", d2, 10);
        check("held_acc2", int'(rf[0]), 0);
        check("held_stop", busy_cnt, 0);

        // ---- sZero stuck at 0: iteration guard ----
        stuck_zero = 1'b1;
        run_op(1, 0, dc, err, saw_add, busy_ok);
        stuck_zero = 1'b0;
        $display("stuck zero: done@%0d err=%0d", dc, err);
        check("guard_cycle", dc, 768);
        check("guard_err", int'(err), 1);
        check("guard_err_sticky", int'(sErr), 1);
        run_op(3, 2, dc, err, saw_add, busy_ok);
        check("guard_clear_err", int'(err), 0);
        check("guard_clear_acc", int'(rf[0]), 6);

        // ---- randomized against reference model ----
        for (int r = 0; r < 16; r++) begin
            int a, n;
            a = int'($urandom_range(0, 255));
            n = int'($urandom_range(0, 12));
            model(a, n, acc_e, cyc_e, err_e);
            run_op(a, n, dc, err, saw_add, busy_ok);
            $display("rand %0d: A=%0d CNT=%0d -> done@%0d acc=%0d err=%0d",
                     r, a, n, dc, rf[0], err);
            check("rand_cycle", dc, cyc_e);
            check("rand_acc", int'(rf[0]), acc_e);
            check("rand_err", int'(err), int'(err_e));
            check("rand_busy", int'(busy_ok), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
